reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset controller that replaces the fixed power-on counter and button-OR logic at the top level. It generates the power-on reset, debounces the reset button, and accepts a soft-reset request from the core. It releases N independent active-low domain resets in a fixed order (domain 0 first), then reports the cause of the last reset. It sits between the board pins and `core`, `led_driver` and the UART.

## Interface
Parameters:
- `POR_BITS`, default 12: width of the power-on counter; POR lasts 2^POR_BITS−1 cycles.
- `DEBOUNCE_BITS`, default 16: the debounced button changes after 2^DEBOUNCE_BITS−1 stable cycles.
- `N_DOMAINS`, default 2: number of reset outputs; must be ≥1.
- `STAGE_GAP`, default 16: cycles between successive domain releases, and from the last release to `ready_o`; must be ≥1.
- `SOFT_HOLD`, default 8: minimum cycles spent in ASSERT; must be ≥1.

Ports:
- `clk` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset of this block; acts as a full cold restart.
- `btn_i` in 1: raw board button, asynchronous, active-high.
- `soft_rst_i` in 1: soft-reset request from the core, synchronous to `clk`; a single-cycle pulse is sufficient.
- `rst_n_o` out N_DOMAINS: per-domain reset, active-low, registered.
- `ready_o` out 1: high once every domain is released and the sequence has completed.
- `cause_o` out 3: cause of the last reset: [0] POR, [1] BTN, [2] SOFT. Sticky until the next reset entry.

## Operation
- **Button path:** `btn_i` passes through 2 synchroniser flops, giving `btn_s`.
  - The debounce counter increments while `btn_s` differs from `btn_db`, and clears when they match.
  - When the counter reaches all-ones, `btn_db` is loaded from `btn_s` and the counter clears.
- **State machine:** POR → RELEASE → RUN, with ASSERT reachable from POR, RELEASE and RUN.
  - **POR:** `por_cnt` increments each cycle. When `por_cnt` is all-ones, set `cause_o`=3'b001.
    - If `btn_db`=1, also set cause bit [1] and go to ASSERT.
    - Otherwise go to RELEASE.
  - **ASSERT:** all `rst_n_o`=0 and `ready_o`=0.
    - The hold counter counts SOFT_HOLD cycles.
    - Exit to RELEASE only when the hold has expired and `btn_db`=0.
    - `soft_rst_i` is ignored in this state.
  - **RELEASE:** on entry, `rst_n_o[0]` rises. Each further `rst_n_o[i]` rises STAGE_GAP cycles after `rst_n_o[i-1]`.
    - STAGE_GAP cycles after `rst_n_o[N_DOMAINS-1]` rises, go to RUN and raise `ready_o`.
    - A release is never reverted except by going to ASSERT.
  - **RUN:** all outputs held.
- **Entry to ASSERT from RELEASE or RUN:**
  - `btn_db`=1 gives `cause_o`=3'b010. `soft_rst_i`=1 gives 3'b100. Both in the same cycle gives 3'b110.
  - On the entry edge: `rst_n_o` goes to all 0, `ready_o` to 0, and the hold counter is cleared.
  - A request during RELEASE aborts the sequence.
- **`btn_db` held high** keeps the block in ASSERT indefinitely.
- **Counter widths:** stage counter is $clog2(STAGE_GAP+1) bits and hold counter is $clog2(SOFT_HOLD+1) bits. Counters saturate and do not wrap. The domain index is $clog2(N_DOMAINS+1) bits.

## Timing
- **`rst_i`=1 at an edge** (regardless of state or counters) sets:
  - state = POR;
  - `por_cnt`, debounce counter, stage counter and hold counter = 0;
  - synchroniser flops and `btn_db` = 0;
  - `rst_n_o` = all 0, `ready_o` = 0, `cause_o` = 0.
- **Cold start:** edge 1 is the first edge with `rst_i`=0.
  - `por_cnt` = 2^POR_BITS−1 after edge 2^POR_BITS−1.
  - `rst_n_o[0]` rises at edge 2^POR_BITS.
  - `rst_n_o[i]` rises at edge 2^POR_BITS + i·STAGE_GAP.
  - `ready_o` rises at edge 2^POR_BITS + N_DOMAINS·STAGE_GAP.
  - `cause_o` becomes valid at edge 2^POR_BITS.
- **Soft request:** `soft_rst_i` sampled high in RUN or RELEASE at edge t gives `rst_n_o`=0 after edge t. `rst_n_o[0]` rises at edge t+SOFT_HOLD+1.
- **Button request:** a `btn_i` change reaches `btn_s` 2 edges later. `btn_db` follows 2^DEBOUNCE_BITS−1 edges after that, provided `btn_s` stays stable. Any glitch shorter than that is filtered out.

## Test plan
- **Cold start**, defaults: `rst_i` high 5 cycles, then low → `rst_n_o[0]` rises at edge 4096, `rst_n_o[1]` at 4112, `ready_o` at 4128, `cause_o`=3'b001.
- **Soft reset:** POR_BITS=4, N_DOMAINS=3, STAGE_GAP=2, SOFT_HOLD=8. In RUN, pulse `soft_rst_i` at edge t → `rst_n_o`=3'b000 after t, domains rise at t+9, t+11, t+13, `ready_o` at t+15, `cause_o`=3'b100.
- **Debounce:** DEBOUNCE_BITS=4.
  - `btn_i` glitch of 10 cycles → no reset.
  - Hold 40 cycles → ASSERT 17 cycles after the press.
  - Stay in ASSERT until 17 cycles after release, then release sequence; `cause_o`=3'b010.
- **Simultaneous requests:** `btn_db` and `soft_rst_i` rise in the same cycle → `cause_o`=3'b110, single ASSERT entry.
- **Abort mid-sequence:** `soft_rst_i` pulsed while `rst_n_o`=2'b01 → `rst_n_o`=2'b00 next edge; full sequence restarts.
- **Reset mid-operation:** `rst_i` asserted in RUN → all outputs 0 next edge; cold-start timing repeats exactly.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: power-on reset, debounced board button and soft-reset
// request from the core, releasing N active-low domain resets in order
// (domain 0 first) and recording the cause of the most recent reset.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_POR     | power-on count running, all domains held in reset
// ST_ASSERT  | all domains held in reset for at least SOFT_HOLD cycles and
//            | for as long as the debounced button stays pressed
// ST_RELEASE | domains released one by one, STAGE_GAP cycles apart
// ST_RUN     | every domain released, ready_o high
module reset_sequencer #(
  parameter int POR_BITS      = 12,
  parameter int DEBOUNCE_BITS = 16,
  parameter int N_DOMAINS     = 2,
  parameter int STAGE_GAP     = 16,
  parameter int SOFT_HOLD     = 8
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 btn_i,
  input  logic                 soft_rst_i,
  output logic [N_DOMAINS-1:0] rst_n_o,
  output logic                 ready_o,
  output logic [2:0]           cause_o
);

  localparam int SW = $clog2(STAGE_GAP + 1);
  localparam int HW = $clog2(SOFT_HOLD + 1);
  localparam int IW = $clog2(N_DOMAINS + 1);

  localparam logic [1:0] ST_POR     = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RUN     = 2'd3;

  localparam logic [POR_BITS-1:0]      POR_DONE  = '1;
  // btn_db is loaded on the edge that would take the counter to all-ones,
  // so the debounced value trails btn_s by 2^DEBOUNCE_BITS-1 edges.
  localparam logic [DEBOUNCE_BITS-1:0] DB_LAST   = {{(DEBOUNCE_BITS-1){1'b1}}, 1'b0};
  localparam logic [SW-1:0]            GAP_LAST  = SW'(STAGE_GAP - 1);
  localparam logic [HW-1:0]            HOLD_DONE = HW'(SOFT_HOLD);
  localparam logic [IW-1:0]            DOM_ALL   = IW'(N_DOMAINS);
  localparam logic [IW-1:0]            DOM_FIRST = IW'(1);
  localparam logic [N_DOMAINS-1:0]     DOM_ONE   = N_DOMAINS'(1);

  logic                     btn_sync1;
  logic                     btn_s;
  logic                     btn_db;
  logic [DEBOUNCE_BITS-1:0] db_cnt;

  logic [1:0]               state;
  logic [POR_BITS-1:0]      por_cnt;
  logic [SW-1:0]            stage_cnt;
  logic [HW-1:0]            hold_cnt;
  logic [IW-1:0]            dom_idx;
  logic [N_DOMAINS-1:0]     rst_n_q;
  logic                     ready_q;
  logic [2:0]               cause_q;

  logic                     req;

  assign req     = btn_db | soft_rst_i;
  assign rst_n_o = rst_n_q;
  assign ready_o = ready_q;
  assign cause_o = cause_q;

  // Two-flop synchroniser for the asynchronous board button.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      btn_sync1 <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      btn_sync1 <= btn_i;
      btn_s     <= btn_sync1;
    end
  end

  // Debounce: btn_db only follows btn_s after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Sequencing FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state     <= ST_POR;
      por_cnt   <= '0;
      stage_cnt <= '0;
      hold_cnt  <= '0;
      dom_idx   <= '0;
      rst_n_q   <= '0;
      ready_q   <= 1'b0;
      cause_q   <= 3'b000;
    end else begin
      case (state)
        ST_POR: begin
          if (por_cnt == POR_DONE) begin
            cause_q <= {1'b0, btn_db, 1'b1};
            if (btn_db) begin
              state    <= ST_ASSERT;
              hold_cnt <= '0;
            end else begin
              state     <= ST_RELEASE;
              rst_n_q   <= DOM_ONE;
              dom_idx   <= DOM_FIRST;
              stage_cnt <= '0;
            end
          end else begin
            por_cnt <= por_cnt + 1'b1;
          end
        end

        ST_ASSERT: begin
          // soft_rst_i is deliberately not looked at while holding.
          if (hold_cnt != HOLD_DONE) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else if (!btn_db) begin
            state     <= ST_RELEASE;
            rst_n_q   <= DOM_ONE;
            dom_idx   <= DOM_FIRST;
            stage_cnt <= '0;
          end
        end

        ST_RELEASE: begin
          if (req) begin
            state    <= ST_ASSERT;
            rst_n_q  <= '0;
            ready_q  <= 1'b0;
            hold_cnt <= '0;
            cause_q  <= {soft_rst_i, btn_db, 1'b0};
          end else if (stage_cnt == GAP_LAST) begin
            stage_cnt <= '0;
            if (dom_idx == DOM_ALL) begin
              state   <= ST_RUN;
              ready_q <= 1'b1;
            end else begin
              // Release order is fixed, so the released set is a thermometer.
              rst_n_q <= (rst_n_q << 1) | DOM_ONE;
              dom_idx <= dom_idx + 1'b1;
            end
          end else begin
            stage_cnt <= stage_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (req) begin
            state    <= ST_ASSERT;
            rst_n_q  <= '0;
            ready_q  <= 1'b0;
            hold_cnt <= '0;
            cause_q  <= {soft_rst_i, btn_db, 1'b0};
          end
        end

        default: begin
          state <= ST_POR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: one instance with default parameters
// for the cold-start timing, one small instance for soft, button,
// simultaneous, abort and mid-operation reset scenarios.
module tb_reset_sequencer;

  logic       clk;
  int         checks;
  int         errors;

  // default-parameter instance
  logic       rst_d, btn_d, soft_d;
  logic [1:0] rst_n_d;
  logic       ready_d;
  logic [2:0] cause_d;

  // small instance: POR_BITS=4, DEBOUNCE_BITS=4, N=3, GAP=2, HOLD=8
  logic       rst_s, btn_s_in, soft_s;
  logic [2:0] rst_n_s;
  logic       ready_s;
  logic [2:0] cause_s;

  reset_sequencer dut_def (
    .clk        (clk),
    .rst_i      (rst_d),
    .btn_i      (btn_d),
    .soft_rst_i (soft_d),
    .rst_n_o    (rst_n_d),
    .ready_o    (ready_d),
    .cause_o    (cause_d)
  );

  reset_sequencer #(
    .POR_BITS      (4),
    .DEBOUNCE_BITS (4),
    .N_DOMAINS     (3),
    .STAGE_GAP     (2),
    .SOFT_HOLD     (8)
  ) dut_small (
    .clk        (clk),
    .rst_i      (rst_s),
    .btn_i      (btn_s_in),
    .soft_rst_i (soft_s),
    .rst_n_o    (rst_n_s),
    .ready_o    (ready_s),
    .cause_o    (cause_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_small(input string tag, input logic [2:0] rn, input logic rdy,
                           input logic [2:0] cause);
    chk({tag, "_rst_n"}, 32'(rst_n_s), 32'(rn));
    chk({tag, "_ready"}, 32'(ready_s), 32'(rdy));
    chk({tag, "_cause"}, 32'(cause_s), 32'(cause));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_d    = 1'b1;
    btn_d    = 1'b0;
    soft_d   = 1'b0;
    rst_s    = 1'b1;
    btn_s_in = 1'b0;
    soft_s   = 1'b0;

    // reset state of both instances
    step(5);
    chk("def_rst_rst_n", 32'(rst_n_d), 32'h0);
    chk("def_rst_ready", 32'(ready_d), 32'h0);
    chk("def_rst_cause", 32'(cause_d), 32'h0);
    chk_small("sm_rst", 3'b000, 1'b0, 3'b000);

    // cold start, default parameters; edge 1 is the next posedge
    rst_d = 1'b0;
    step(4095);
    chk("def_e4095_rst_n", 32'(rst_n_d), 32'h0);
    chk("def_e4095_cause", 32'(cause_d), 32'h0);
    step(1);
    chk("def_e4096_rst_n", 32'(rst_n_d), 32'h1);
    chk("def_e4096_cause", 32'(cause_d), 32'h1);
    step(15);
    chk("def_e4111_rst_n", 32'(rst_n_d), 32'h1);
    step(1);
    chk("def_e4112_rst_n", 32'(rst_n_d), 32'h3);
    chk("def_e4112_ready", 32'(ready_d), 32'h0);
    step(15);
    chk("def_e4127_ready", 32'(ready_d), 32'h0);
    step(1);
    chk("def_e4128_ready", 32'(ready_d), 32'h1);
    chk("def_e4128_cause", 32'(cause_d), 32'h1);

    // cold start, small instance
    rst_s = 1'b0;
    step(15);
    chk_small("sm_cold_e15", 3'b000, 1'b0, 3'b000);
    step(1);
    chk_small("sm_cold_e16", 3'b001, 1'b0, 3'b001);
    step(2);
    chk_small("sm_cold_e18", 3'b011, 1'b0, 3'b001);
    step(2);
    chk_small("sm_cold_e20", 3'b111, 1'b0, 3'b001);
    step(1);
    chk_small("sm_cold_e21", 3'b111, 1'b0, 3'b001);
    step(1);
    chk_small("sm_cold_e22", 3'b111, 1'b1, 3'b001);

    // soft reset pulse in RUN at edge t
    soft_s = 1'b1;
    step(1);
    soft_s = 1'b0;
    chk_small("soft_t", 3'b000, 1'b0, 3'b100);
    step(8);
    chk_small("soft_t8", 3'b000, 1'b0, 3'b100);
    step(1);
    chk_small("soft_t9", 3'b001, 1'b0, 3'b100);
    step(2);
    chk_small("soft_t11", 3'b011, 1'b0, 3'b100);
    step(2);
    chk_small("soft_t13", 3'b111, 1'b0, 3'b100);
    step(1);
    chk_small("soft_t14", 3'b111, 1'b0, 3'b100);
    step(1);
    chk_small("soft_t15", 3'b111, 1'b1, 3'b100);

    // 10-cycle button glitch is filtered
    btn_s_in = 1'b1;
    step(10);
    btn_s_in = 1'b0;
    step(30);
    chk_small("glitch", 3'b111, 1'b1, 3'b100);

    // button held 40 cycles; first sampled high at edge p
    btn_s_in = 1'b1;
    step(16);
    chk_small("btn_p15", 3'b111, 1'b1, 3'b100);
    step(1);
    chk_small("btn_p16", 3'b111, 1'b1, 3'b100);
    step(1);
    chk_small("btn_p17", 3'b000, 1'b0, 3'b010);
    step(23);
    btn_s_in = 1'b0;
    // first sampled low at edge r
    step(16);
    chk_small("btn_r15", 3'b000, 1'b0, 3'b010);
    step(1);
    chk_small("btn_r16", 3'b000, 1'b0, 3'b010);
    step(1);
    chk_small("btn_r17", 3'b001, 1'b0, 3'b010);
    step(2);
    chk_small("btn_r19", 3'b011, 1'b0, 3'b010);
    step(2);
    chk_small("btn_r21", 3'b111, 1'b0, 3'b010);
    step(2);
    chk_small("btn_r23", 3'b111, 1'b1, 3'b010);

    // btn_db rises in the same cycle soft_rst_i is sampled
    btn_s_in = 1'b1;
    step(17);
    chk_small("sim_pre", 3'b111, 1'b1, 3'b010);
    soft_s = 1'b1;
    step(1);
    soft_s = 1'b0;
    chk_small("sim_entry", 3'b000, 1'b0, 3'b110);
    btn_s_in = 1'b0;
    step(5);
    chk_small("sim_hold", 3'b000, 1'b0, 3'b110);
    step(12);
    chk_small("sim_r16", 3'b000, 1'b0, 3'b110);
    step(1);
    chk_small("sim_r17", 3'b001, 1'b0, 3'b110);
    step(6);
    chk_small("sim_r23", 3'b111, 1'b1, 3'b110);

    // abort during RELEASE while only domain 0 is out of reset
    soft_s = 1'b1;
    step(1);
    soft_s = 1'b0;
    step(9);
    chk_small("abort_t9", 3'b001, 1'b0, 3'b100);
    soft_s = 1'b1;
    step(1);
    soft_s = 1'b0;
    chk_small("abort_t10", 3'b000, 1'b0, 3'b100);
    step(8);
    chk_small("abort_t18", 3'b000, 1'b0, 3'b100);
    step(1);
    chk_small("abort_t19", 3'b001, 1'b0, 3'b100);
    step(4);
    chk_small("abort_t23", 3'b111, 1'b0, 3'b100);
    step(2);
    chk_small("abort_t25", 3'b111, 1'b1, 3'b100);

    // rst_i in RUN, then cold-start timing again
    rst_s = 1'b1;
    step(1);
    chk_small("mid_rst", 3'b000, 1'b0, 3'b000);
    step(1);
    rst_s = 1'b0;
    step(15);
    chk_small("mid_e15", 3'b000, 1'b0, 3'b000);
    step(1);
    chk_small("mid_e16", 3'b001, 1'b0, 3'b001);
    step(2);
    chk_small("mid_e18", 3'b011, 1'b0, 3'b001);
    step(2);
    chk_small("mid_e20", 3'b111, 1'b0, 3'b001);
    step(2);
    chk_small("mid_e22", 3'b111, 1'b1, 3'b001);

    // default instance undisturbed throughout
    chk("def_end_rst_n", 32'(rst_n_d), 32'h3);
    chk("def_end_ready", 32'(ready_d), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
